slc3_datapath_mem: RTL

// Parametrised SLC-3 datapath: PC, IR, MAR, MDR, 8x W-bit regfile, ALU, address adder, CC/BEN, LED.

---
 rtl/slc3_datapath_mem_if.sv | 23 ++
 rtl/slc3_datapath_mem.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_datapath_mem_if.sv
// Memory handshake bundle between the SLC-3 datapath (master) and memory (slave).
// The datapath raises mem_req/mem_we and pulses mem_done/mem_tmo.
// Memory answers with mem_rdy and read data on MDR_in.
interface slc3_datapath_mem_if #(
    parameter int W = 16
);
    logic         mem_req;
    logic         mem_we;
    logic         mem_done;
    logic         mem_tmo;
    logic         mem_rdy;
    logic [W-1:0] MDR_in;

    modport master (
        output mem_req, mem_we, mem_done, mem_tmo,
        input  mem_rdy, MDR_in
    );

    modport slave (
        input  mem_req, mem_we, mem_done, mem_tmo,
        output mem_rdy, MDR_in
    );
endinterface

// File: rtl/slc3_datapath_mem.sv
// SLC-3 datapath with a handshaked memory access engine.
// Contents: PC, IR, MAR, MDR, an 8 x W register file, ALU, address adder, CC/BEN and LED.
// MDR is filled by a mem_req/mem_rdy handshake. The handshake aborts after TIMEOUT
// cycles of waiting.
// Optional feature: define SLC3_DP_BUS_CHECK_EN to add a sticky bus_err output.
// bus_err flags multiple bus gates, and MEM_RD together with MEM_WR while idle.
module slc3_datapath_mem #(
    parameter int             W       = 16,
    parameter int             LED_W   = 12,
    parameter int             TIMEOUT = 15,
    parameter logic [W-1:0]   PC_RST  = {W{1'b0}}
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               LD_MAR,
    input  logic               LD_MDR,
    input  logic               LD_IR,
    input  logic               LD_BEN,
    input  logic               LD_CC,
    input  logic               LD_REG,
    input  logic               LD_PC,
    input  logic               LD_LED,
    input  logic               GatePC,
    input  logic               GateMDR,
    input  logic               GateALU,
    input  logic               GateMARMUX,
    input  logic               SR2MUX,
    input  logic               ADDR1MUX,
    input  logic               MARMUX,
    input  logic               DRMUX,
    input  logic               SR1MUX,
    input  logic               MIO_EN,
    input  logic [1:0]         PCMUX,
    input  logic [1:0]         ADDR2MUX,
    input  logic [1:0]         ALUK,
    input  logic               MEM_RD,
    input  logic               MEM_WR,
    slc3_datapath_mem_if.master mem,
    output logic [W-1:0]       MAR,
    output logic [W-1:0]       MDR,
    output logic [W-1:0]       PC,
    output logic [W-1:0]       IR,
    output logic               BEN,
    output logic [LED_W-1:0]   LED
`ifdef SLC3_DP_BUS_CHECK_EN
    ,
    output logic               bus_err
`endif
);

    // Memory engine states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    // Architectural state
    logic [W-1:0]     pc_q,  pc_d;
    logic [W-1:0]     ir_q,  ir_d;
    logic [W-1:0]     mar_q, mar_d;
    logic [W-1:0]     mdr_q, mdr_d;
    logic [W-1:0]     reg_q [8];
    logic [W-1:0]     reg_d [8];
    logic [2:0]       cc_q,  cc_d;      // {N, Z, P}
    logic             ben_q, ben_d;
    logic [LED_W-1:0] led_q, led_d;

    // Memory engine state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             wr_op_q, wr_op_d;
    logic             mem_req_q,  mem_req_d;
    logic             mem_we_q,   mem_we_d;
    logic             mem_done_q, mem_done_d;
    logic             mem_tmo_q,  mem_tmo_d;
    logic             bus_err_q,  bus_err_d;

    // Datapath combinational nets
    logic [2:0]   sr1_idx_s;
    logic [2:0]   dr_idx_s;
    logic [W-1:0] sr1_val_s;
    logic [W-1:0] sr2_val_s;
    logic [W-1:0] alu_b_s;
    logic [W-1:0] alu_s;
    logic [W-1:0] addr1_s;
    logic [W-1:0] addr2_s;
    logic [W-1:0] adder_s;
    logic [W-1:0] marmux_s;
    logic [W-1:0] bus_s;
    logic         mdr_fill_s;
    logic [2:0]   gate_cnt_s;

    // Register-file read ports, ALU operand select and ALU operation
    always_comb begin
        sr1_idx_s = SR1MUX ? ir_q[8:6] : ir_q[11:9];
        dr_idx_s  = DRMUX ? 3'd7 : ir_q[11:9];
        sr1_val_s = reg_q[sr1_idx_s];
        sr2_val_s = reg_q[ir_q[2:0]];
        alu_b_s   = SR2MUX ? {{(W-5){ir_q[4]}}, ir_q[4:0]} : sr2_val_s;
        case (ALUK)
            2'b00:   alu_s = sr1_val_s + alu_b_s;
            2'b01:   alu_s = sr1_val_s & alu_b_s;
            2'b10:   alu_s = ~sr1_val_s;
            2'b11:   alu_s = sr1_val_s;
            default: alu_s = {W{1'b0}};
        endcase
    end

    // Address adder and MARMUX
    always_comb begin
        addr1_s = ADDR1MUX ? sr1_val_s : pc_q;
        case (ADDR2MUX)
            2'b00:   addr2_s = {W{1'b0}};
            2'b01:   addr2_s = {{(W-6){ir_q[5]}},   ir_q[5:0]};
            2'b10:   addr2_s = {{(W-9){ir_q[8]}},   ir_q[8:0]};
            2'b11:   addr2_s = {{(W-11){ir_q[10]}}, ir_q[10:0]};
            default: addr2_s = {W{1'b0}};
        endcase
        adder_s  = addr1_s + addr2_s;
        marmux_s = MARMUX ? {{(W-8){1'b0}}, ir_q[7:0]} : adder_s;
    end

    // Shared bus: priority ALU > MARMUX > MDR > PC, zero when nothing drives it
    always_comb begin
        if (GateALU) begin
            bus_s = alu_s;
        end else if (GateMARMUX) begin
            bus_s = marmux_s;
        end else if (GateMDR) begin
            bus_s = mdr_q;
        end else if (GatePC) begin
            bus_s = pc_q;
        end else begin
            bus_s = {W{1'b0}};
        end
    end

    // Memory engine: IDLE -> REQ -> WAIT -> IDLE, with completion or timeout
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_op_d    = wr_op_q;
        mem_done_d = 1'b0;
        mem_tmo_d  = 1'b0;
        mdr_fill_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MEM_RD) begin
                    state_d = ST_REQ;
                    wr_op_d = 1'b0;
                end else if (MEM_WR) begin
                    state_d = ST_REQ;
                    wr_op_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                if (mem.mem_rdy) begin
                    state_d    = ST_IDLE;
                    mem_done_d = 1'b1;
                    mdr_fill_s = ~wr_op_q;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    mem_tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Request lines are registered copies of the next state.
        mem_req_d = (state_d != ST_IDLE);
        mem_we_d  = (state_d != ST_IDLE) & wr_op_d;
    end

    // Next-state values for the architectural registers
    always_comb begin
        mar_d = LD_MAR ? bus_s : mar_q;
        ir_d  = LD_IR  ? bus_s : ir_q;
        led_d = LD_LED ? ir_q[LED_W-1:0] : led_q;

        // A completed memory read owns MDR; LD_MDR only acts when MIO_EN is low.
        if (mdr_fill_s) begin
            mdr_d = mem.MDR_in;
        end else if (LD_MDR && !MIO_EN) begin
            mdr_d = bus_s;
        end else begin
            mdr_d = mdr_q;
        end

        case (PCMUX)
            2'b00:   pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
            2'b01:   pc_d = bus_s;
            2'b10:   pc_d = adder_s;
            2'b11:   pc_d = pc_q;
            default: pc_d = pc_q;
        endcase
        if (!LD_PC) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_d;
        end

        for (int i = 0; i < 8; i++) begin
            reg_d[i] = reg_q[i];
        end
        if (LD_REG) begin
            reg_d[dr_idx_s] = bus_s;
        end else begin
            reg_d[dr_idx_s] = reg_q[dr_idx_s];
        end

        if (!LD_CC) begin
            cc_d = cc_q;
        end else if (bus_s[W-1]) begin
            cc_d = 3'b100;
        end else if (bus_s == {W{1'b0}}) begin
            cc_d = 3'b010;
        end else begin
            cc_d = 3'b001;
        end

        // BEN looks at the CC value from before any same-cycle LD_CC.
        if (LD_BEN) begin
            ben_d = (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);
        end else begin
            ben_d = ben_q;
        end
    end

    // Sticky bus-misuse flag: several gates at once, or read and write strobed together while idle
    always_comb begin
        gate_cnt_s = {2'b00, GatePC} + {2'b00, GateMDR} + {2'b00, GateALU} + {2'b00, GateMARMUX};
        bus_err_d  = bus_err_q | (gate_cnt_s > 3'd1) |
                     ((state_q == ST_IDLE) & MEM_RD & MEM_WR);
    end

    // All state registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= PC_RST;
            ir_q       <= {W{1'b0}};
            mar_q      <= {W{1'b0}};
            mdr_q      <= {W{1'b0}};
            for (int i = 0; i < 8; i++) begin
                reg_q[i] <= {W{1'b0}};
            end
            cc_q       <= 3'b010;
            ben_q      <= 1'b0;
            led_q      <= {LED_W{1'b0}};
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            wr_op_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_done_q <= 1'b0;
            mem_tmo_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            for (int i = 0; i < 8; i++) begin
                reg_q[i] <= reg_d[i];
            end
            cc_q       <= cc_d;
            ben_q      <= ben_d;
            led_q      <= led_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_op_q    <= wr_op_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_done_q <= mem_done_d;
            mem_tmo_q  <= mem_tmo_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign MAR          = mar_q;
    assign MDR          = mdr_q;
    assign PC           = pc_q;
    assign IR           = ir_q;
    assign BEN          = ben_q;
    assign LED          = led_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_done = mem_done_q;
    assign mem.mem_tmo  = mem_tmo_q;

`ifdef SLC3_DP_BUS_CHECK_EN
    assign bus_err = bus_err_q;
`else
    logic bus_err_unused_s;
    assign bus_err_unused_s = bus_err_q;
`endif

endmodule
